// File: rtl/gpu_ram_arb.sv
// Three-way arbiter/sequencer in front of the single-port GPU local RAM, with read-return routing.
// Optional conflict statistics counter enabled by defining GPU_RAM_ARB_STATS_EN.
module gpu_ram_arb #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  input  logic          pf_req,
  input  logic [AW-1:0] pf_addr,
  output logic          pf_ack,
  output logic          pf_rvalid,
  output logic [DW-1:0] pf_rdata,
`ifdef GPU_RAM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   conflict_cnt,
`endif
  output logic [AW-1:0] rama,
  output logic          ramen,
  output logic          ramwe,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_HOST, SRC_LS, SRC_PF} src_t;

  state_t        state, next_state;
  src_t          winner;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          issue;
  logic [3:0]    starve_cnt;
  src_t          rd_src_issue, rd_src_data;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner    = SRC_NONE;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (pf_req && starve_cnt == 4'(STARVE_LIMIT)) winner = SRC_PF;
    else if (host_req)                            winner = SRC_HOST;
    else if (ls_req)                              winner = SRC_LS;
    else if (pf_req)                              winner = SRC_PF;

    case (winner)
      SRC_HOST: begin win_we = host_we; win_addr = host_addr; win_wdata = host_wdata; end
      SRC_LS:   begin win_we = ls_we;   win_addr = ls_addr;   win_wdata = ls_wdata;   end
      SRC_PF:   begin win_addr = pf_addr; end
      default:  ;
    endcase

    // A write straight after a read burns one dead cycle; the write is re-arbitrated next edge.
    next_state = IDLE;
    issue      = 1'b0;
    if (winner != SRC_NONE) begin
      if (win_we && state == RD) begin
        next_state = TURN;
      end else begin
        issue      = 1'b1;
        next_state = win_we ? WR : RD;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rama       <= '0;
      ramen      <= 1'b0;
      ramwe      <= 1'b0;
      ram_wdata  <= '0;
      host_ack   <= 1'b0;
      ls_ack     <= 1'b0;
      pf_ack     <= 1'b0;
    end else begin
      state      <= next_state;
      rama       <= issue ? win_addr : '0;
      ramen      <= issue;
      ramwe      <= issue && win_we;
      ram_wdata  <= (issue && win_we) ? win_wdata : '0;
      host_ack   <= issue && winner == SRC_HOST;
      ls_ack     <= issue && winner == SRC_LS;
      pf_ack     <= issue && winner == SRC_PF;
      if (!pf_req || (issue && winner == SRC_PF)) starve_cnt <= '0;
      else                                        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Read return: tag rides alongside the RAM for two cycles, then steers ram_rdata to its owner.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      rd_src_issue <= SRC_NONE;
      rd_src_data  <= SRC_NONE;
      host_rvalid  <= 1'b0;
      ls_rvalid    <= 1'b0;
      pf_rvalid    <= 1'b0;
      host_rdata   <= '0;
      ls_rdata     <= '0;
      pf_rdata     <= '0;
    end else begin
      rd_src_issue <= (issue && !win_we) ? winner : SRC_NONE;
      rd_src_data  <= rd_src_issue;
      host_rvalid  <= rd_src_data == SRC_HOST;
      ls_rvalid    <= rd_src_data == SRC_LS;
      pf_rvalid    <= rd_src_data == SRC_PF;
      if (rd_src_data == SRC_HOST) host_rdata <= ram_rdata;
      if (rd_src_data == SRC_LS)   ls_rdata   <= ram_rdata;
      if (rd_src_data == SRC_PF)   pf_rdata   <= ram_rdata;
    end
  end

`ifdef GPU_RAM_ARB_STATS_EN
  logic [1:0] pending;
  assign pending = 2'(host_req) + 2'(ls_req) + 2'(pf_req);

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl)                                      conflict_cnt <= '0;
    else if (stats_clr)                               conflict_cnt <= '0;
    else if (pending >= 2'd2 && conflict_cnt != '1)   conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_gpu_ram_arb.sv
// Self-checking bench for gpu_ram_arb: directed scenarios plus a randomized run against
// a cycle-level reference model of the arbitration rules and a shadow memory.
module tb_gpu_ram_arb;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int NRAND = 400;

  logic          sys_clk = 1'b0;
  logic          resetl  = 1'b0;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_ack, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          pf_req = 1'b0;
  logic [AW-1:0] pf_addr = '0;
  logic          pf_ack, pf_rvalid;
  logic [DW-1:0] pf_rdata;
  logic [AW-1:0] rama;
  logic          ramen, ramwe;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef GPU_RAM_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  gpu_ram_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .sys_clk(sys_clk), .resetl(resetl),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .pf_req(pf_req), .pf_addr(pf_addr),
    .pf_ack(pf_ack), .pf_rvalid(pf_rvalid), .pf_rdata(pf_rdata),
`ifdef GPU_RAM_ARB_STATS_EN
    .stats_clr(stats_clr), .conflict_cnt(conflict_cnt),
`endif
    .rama(rama), .ramen(ramen), .ramwe(ramwe), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural single-port synchronous RAM, preloaded on the first clock edge.
  function automatic logic [DW-1:0] init_val(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  logic [DW-1:0] ram_mem [1024];
  bit            ram_init_done;
  always @(posedge sys_clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else if (ramen) begin
      if (ramwe) ram_mem[rama] <= ram_wdata;
      else       ram_rdata     <= ram_mem[rama];
    end
  end

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    resetl = 1'b0;
    tick();
    checks++;
    if ({host_ack, ls_ack, pf_ack, host_rvalid, ls_rvalid, pf_rvalid, ramen, ramwe} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000000",
               {host_ack, ls_ack, pf_ack, host_rvalid, ls_rvalid, pf_rvalid, ramen, ramwe});
    end
    checks++;
    if ({rama, ram_wdata, host_rdata, ls_rdata, pf_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data rama=%h wdata=%h hrd=%h lrd=%h prd=%h",
               rama, ram_wdata, host_rdata, ls_rdata, pf_rdata);
    end
`ifdef GPU_RAM_ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_conf got=%0d exp=0", conflict_cnt); end
`endif
    resetl = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h005; host_wdata = 32'hDEADBEEF;
    tick();
    checks++;
    if ({host_ack, ramen, ramwe, rama, ram_wdata} !== {3'b111, 10'h005, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL wr_issue ack=%b en=%b we=%b a=%h d=%h exp 1 1 1 005 deadbeef",
               host_ack, ramen, ramwe, rama, ram_wdata);
    end
    host_we = 1'b0;
    tick();
    checks++;
    if ({host_ack, ramen, ramwe, rama, ram_wdata} !== {3'b110, 10'h005, 32'h0}) begin
      errors++;
      $display("FAIL rd_issue ack=%b en=%b we=%b a=%h d=%h exp 1 1 0 005 0",
               host_ack, ramen, ramwe, rama, ram_wdata);
    end
    host_req = 1'b0;
    tick();
    checks++;
    if (host_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early rvalid=%b exp=0", host_rvalid); end
    tick();
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_return rvalid=%b rdata=%h exp 1 deadbeef", host_rvalid, host_rdata);
    end
    tick();
    checks++;
    if (host_rvalid !== 1'b0 || host_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_hold rvalid=%b rdata=%h exp 0 deadbeef", host_rvalid, host_rdata);
    end
  endtask

  task automatic test_two_readers();
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'd7;
    ls_req   = 1'b1; ls_we   = 1'b0; ls_addr   = 10'd8;
    tick();
    checks++;
    if ({host_ack, ls_ack} !== 2'b10) begin errors++; $display("FAIL prio_c1 acks=%b exp=10", {host_ack, ls_ack}); end
    host_req = 1'b0;
    tick();
    checks++;
    if ({host_ack, ls_ack} !== 2'b01) begin errors++; $display("FAIL prio_c2 acks=%b exp=01", {host_ack, ls_ack}); end
    ls_req = 1'b0;
    tick();
    checks++;
    if ({host_rvalid, ls_rvalid} !== 2'b10 || host_rdata !== init_val(7)) begin
      errors++;
      $display("FAIL prio_rv1 rv=%b hrd=%h exp 10 %h", {host_rvalid, ls_rvalid}, host_rdata, init_val(7));
    end
    tick();
    checks++;
    if ({host_rvalid, ls_rvalid} !== 2'b01 || ls_rdata !== init_val(8)) begin
      errors++;
      $display("FAIL prio_rv2 rv=%b lrd=%h exp 01 %h", {host_rvalid, ls_rvalid}, ls_rdata, init_val(8));
    end
    tick();
  endtask

  task automatic test_turnaround();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h010;
    tick();
    checks++;
    if ({ls_ack, ramen, ramwe, rama} !== {3'b110, 10'h010}) begin
      errors++;
      $display("FAIL turn_rd ack=%b en=%b we=%b a=%h exp 1 1 0 010", ls_ack, ramen, ramwe, rama);
    end
    ls_req = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h011; host_wdata = 32'h1234_5678;
    tick();
    checks++;
    if ({ramen, host_ack, ls_ack, pf_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL turn_dead en=%b acks=%b exp 0 000", ramen, {host_ack, ls_ack, pf_ack});
    end
    tick();
    checks++;
    if ({host_ack, ramen, ramwe, rama, ram_wdata} !== {3'b111, 10'h011, 32'h1234_5678}) begin
      errors++;
      $display("FAIL turn_wr ack=%b en=%b we=%b a=%h d=%h exp 1 1 1 011 12345678",
               host_ack, ramen, ramwe, rama, ram_wdata);
    end
    checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== init_val(16)) begin
      errors++;
      $display("FAIL turn_rv rvalid=%b rdata=%h exp 1 %h", ls_rvalid, ls_rdata, init_val(16));
    end
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'd1;
    ls_req   = 1'b1; ls_we   = 1'b0; ls_addr   = 10'd2;
    pf_req   = 1'b1; pf_addr = 10'd3;
    for (int t = 1; t <= 10; t++) begin
      bit exp_pf;
      tick();
      exp_pf = (t == LIMIT + 1) || (t == 2 * (LIMIT + 1));
      checks++;
      if ({host_ack, ls_ack, pf_ack} !== {!exp_pf, 1'b0, exp_pf}) begin
        errors++;
        $display("FAIL starve_c%0d acks=%b exp=%b", t, {host_ack, ls_ack, pf_ack}, {!exp_pf, 1'b0, exp_pf});
      end
    end
    host_req = 1'b0; ls_req = 1'b0; pf_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_pf_burst();
    host_req = 1'b1; host_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_addr = AW'(i); host_wdata = DW'(i);
      tick();
      checks++;
      if (host_ack !== 1'b1 || ram_wdata !== DW'(i)) begin
        errors++;
        $display("FAIL preload_%0d ack=%b wdata=%h exp 1 %h", i, host_ack, ram_wdata, DW'(i));
      end
    end
    host_req = 1'b0; host_we = 1'b0;
    pf_req = 1'b1; pf_addr = '0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      checks++;
      if (pf_ack !== (t <= 8)) begin errors++; $display("FAIL burst_ack_%0d got=%b exp=%b", t, pf_ack, t <= 8); end
      checks++;
      if (pf_rvalid !== (t >= 3 && t <= 10) || (t >= 3 && t <= 10 && pf_rdata !== DW'(t - 3))) begin
        errors++;
        $display("FAIL burst_rv_%0d rvalid=%b rdata=%h exp %b %h", t, pf_rvalid, pf_rdata,
                 t >= 3 && t <= 10, DW'(t - 3));
      end
      if (t < 8) pf_addr = AW'(t);
      else       pf_req  = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'd9;
    ls_req   = 1'b1; ls_we   = 1'b0; ls_addr   = 10'd10;
    tick();
    resetl = 1'b0; host_req = 1'b0; ls_req = 1'b0;
    #1;
    checks++;
    if ({host_ack, ls_ack, pf_ack, host_rvalid, ls_rvalid, pf_rvalid, ramen} !== 7'h00) begin
      errors++;
      $display("FAIL midrst_out got=%b exp=0000000",
               {host_ack, ls_ack, pf_ack, host_rvalid, ls_rvalid, pf_rvalid, ramen});
    end
`ifdef GPU_RAM_ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL midrst_conf got=%0d exp=0", conflict_cnt); end
`endif
    tick();
    resetl = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if ({host_rvalid, ls_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_rv_%0d rv=%b exp=00", t, {host_rvalid, ls_rvalid});
      end
    end
  endtask

  // Reference model state for the randomized run (ports: 1 host, 2 ls, 3 pf).
  logic [DW-1:0] ref_mem [1024];
  bit            exp_rv [4][4];
  logic [DW-1:0] exp_rd [4][4];
  logic [DW-1:0] last_rd [4];

  task automatic test_random();
    int gnt = 0, starve = 0, conf = 0;
    bit gwe, prev_read = 1'b0;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gdata;
    resetl = 1'b0; host_req = 1'b0; ls_req = 1'b0; pf_req = 1'b0;
    tick();
    resetl = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram_mem[i];
    for (int p = 0; p < 4; p++) begin
      last_rd[p] = '0;
      for (int s = 0; s < 4; s++) exp_rv[p][s] = 1'b0;
    end
    for (int n = 1; n <= NRAND + 12; n++) begin
      bit quiet = n > NRAND;
      int obs_rv;
      logic [DW-1:0] obs_rd;
      if (!host_req || gnt == 1) begin
        host_req = !quiet && $urandom_range(0, 2) != 0; host_we = 1'($urandom_range(0, 1));
        host_addr = AW'($urandom_range(0, 15)); host_wdata = $urandom;
      end
      if (!ls_req || gnt == 2) begin
        ls_req = !quiet && $urandom_range(0, 2) != 0; ls_we = 1'($urandom_range(0, 1));
        ls_addr = AW'($urandom_range(0, 15)); ls_wdata = $urandom;
      end
      if (!pf_req || gnt == 3) begin
        pf_req = !quiet && $urandom_range(0, 1) != 0; pf_addr = AW'($urandom_range(0, 15));
      end
      // Who gets the RAM on this edge, by the priority and starvation rules.
      if (pf_req && starve == LIMIT) gnt = 3;
      else if (host_req)             gnt = 1;
      else if (ls_req)               gnt = 2;
      else if (pf_req)               gnt = 3;
      else                           gnt = 0;
      gwe   = (gnt == 1) ? host_we : (gnt == 2) ? ls_we : 1'b0;
      gaddr = (gnt == 1) ? host_addr : (gnt == 2) ? ls_addr : pf_addr;
      gdata = (gnt == 1) ? host_wdata : ls_wdata;
      if (gnt != 0 && gwe && prev_read) gnt = 0;
      prev_read = gnt != 0 && !gwe;
      starve = (pf_req && gnt != 3) ? starve + 1 : 0;
      if (int'(host_req) + int'(ls_req) + int'(pf_req) >= 2) conf++;
      if (gnt != 0) begin
        if (gwe) ref_mem[gaddr] = gdata;
        else begin
          exp_rv[gnt][(n + 2) % 4] = 1'b1;
          exp_rd[gnt][(n + 2) % 4] = ref_mem[gaddr];
        end
      end
      tick();
      checks++;
      if ({host_ack, ls_ack, pf_ack, ramen, ramwe} !== {gnt == 1, gnt == 2, gnt == 3, gnt != 0, gnt != 0 && gwe}) begin
        errors++;
        $display("FAIL rnd_ctrl_%0d got=%b exp=%b", n, {host_ack, ls_ack, pf_ack, ramen, ramwe},
                 {gnt == 1, gnt == 2, gnt == 3, gnt != 0, gnt != 0 && gwe});
      end
      checks++;
      if ((gnt != 0 && rama !== gaddr) || ram_wdata !== ((gnt != 0 && gwe) ? gdata : '0)) begin
        errors++;
        $display("FAIL rnd_bus_%0d rama=%h wdata=%h exp %h %h", n, rama, ram_wdata, gaddr,
                 (gnt != 0 && gwe) ? gdata : '0);
      end
      for (int p = 1; p <= 3; p++) begin
        case (p)
          1:       begin obs_rv = int'(host_rvalid); obs_rd = host_rdata; end
          2:       begin obs_rv = int'(ls_rvalid);   obs_rd = ls_rdata;   end
          default: begin obs_rv = int'(pf_rvalid);   obs_rd = pf_rdata;   end
        endcase
        if (exp_rv[p][n % 4]) last_rd[p] = exp_rd[p][n % 4];
        checks++;
        if (obs_rv != int'(exp_rv[p][n % 4]) || obs_rd !== last_rd[p]) begin
          errors++;
          $display("FAIL rnd_rv_%0d_p%0d rvalid=%0d rdata=%h exp %0d %h", n, p, obs_rv, obs_rd,
                   exp_rv[p][n % 4], last_rd[p]);
        end
        exp_rv[p][n % 4] = 1'b0;
      end
    end
`ifdef GPU_RAM_ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 16'(conf)) begin errors++; $display("FAIL rnd_conf got=%0d exp=%0d", conflict_cnt, conf); end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    checks++;
    if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL stats_clr got=%0d exp=0", conflict_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_two_readers();
    test_turnaround();
    test_starvation();
    test_pf_burst();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_ram_arb.md
Name: gpu_ram_arb

Overview:
- Arbiter and sequencer directly upstream of the GPU local RAM (1K x 32, single port, chip-select/write-enable interface).
- Merges three requesters into one RAM access per cycle and returns read data to the originator:
  - host bus (CPU/blitter reads/writes of GPU RAM)
  - GPU load/store unit
  - GPU instruction prefetch (read-only)
- Inserts the read-to-write bus turnaround the shared RAM data path needs.

Parameters:
- AW, 10, RAM word-address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive denied cycles after which prefetch is force-granted; legal range 1..15.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- resetl  in  1  asynchronous active-low reset.
- host_req  in  1  host access request, held until host_ack.
- host_we  in  1  1 = write.
- host_addr  in  AW  host word address.
- host_wdata  in  DW  host write data.
- host_ack  out  1  one-cycle pulse: host command issued to RAM this cycle.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid.
- host_rdata  out  DW  host read data.
- ls_req, ls_we, ls_addr, ls_wdata  in  1/1/AW/DW  load/store request, same rules as host.
- ls_ack, ls_rvalid  out  1  as host.
- ls_rdata  out  DW  as host.
- pf_req  in  1  prefetch read request.
- pf_addr  in  AW  prefetch address.
- pf_ack, pf_rvalid  out  1  as host.
- pf_rdata  out  DW  as host.
- rama  out  AW  RAM address.
- ramen  out  1  RAM enable (chip select source).
- ramwe  out  1  RAM write enable.
- ram_wdata  out  DW  data to RAM.
- ram_rdata  in  DW  data from RAM, valid the cycle after a read issue.

Behaviour:
- Reset (async, resetl=0): all outputs 0; FSM=IDLE; starve counter=0; read pipeline cleared. Deassertion is synchronised by the surrounding clock domain; no further requirement here.
- FSM states:
  - IDLE: no access issued.
  - RD: read issued this cycle.
  - WR: write issued this cycle.
  - TURN: dead cycle, ramen=0.
- Transitions, evaluated each edge from the winning request:
  - Winner is a read -> RD.
  - Winner is a write and current state is not RD -> WR.
  - Winner is a write and current state is RD -> TURN, then WR on the next edge. The write is re-arbitrated in TURN; a newly arrived higher-priority request may win instead.
  - No request -> IDLE.
- Priority: host > ls > pf, fixed, with starvation override.
  - Starve counter increments each cycle pf_req=1 and pf loses; it clears when pf is granted or pf_req=0.
  - Counter == STARVE_LIMIT: pf wins regardless of other requests.
- Issue cycle outputs (all registered):
  - rama/ramwe/ram_wdata from winner; ramen=1.
  - Winner's ack=1 for exactly that cycle.
  - Requesters must drop or change their request after ack; a request still high after ack is a new access.
- Read return:
  - RAM drives ram_rdata in issue+1.
  - Arbiter registers it at the end of issue+1 into the originator's rdata.
  - Originator's rvalid=1 in issue+2.
  - Latency ack->rvalid = 2 cycles, fully pipelined: back-to-back reads give back-to-back rvalids in issue order.
- rdata holds its last value until the next rvalid for that port.
- Writes produce no rvalid.
- ram_wdata is 0 in non-write cycles.
- Same-address write then read on consecutive cycles: the read returns the new data (RAM is write-first; the arbiter does not reorder).
- Reset mid-operation: in-flight reads are discarded, no rvalid is produced after reset; requesters re-issue.

Optional Feature:
- Macro: GPU_RAM_ARB_STATS_EN.
- When defined, adds:
  - output conflict_cnt (16 bits): increments (saturating at 16'hFFFF) each cycle where two or more requests are pending.
  - input stats_clr (1 bit): synchronous clear of conflict_cnt.
  - Both reset to 0.
- When undefined, neither port exists and no counter logic is generated.

Test Plan:
- Host write addr 10'h005 data 32'hDEADBEEF, then host read 10'h005 -> WR then RD; host_rvalid two cycles after second ack with host_rdata=32'hDEADBEEF.
- host_req and ls_req both reading, same cycle -> host_ack first, ls_ack next cycle; rvalids in same order, one cycle apart.
- ls read 10'h010 followed immediately by host write 10'h011 -> RD, TURN (ramen=0), WR; host_ack in WR cycle.
- Host and ls requesting continuously, pf_req=1, STARVE_LIMIT=4 -> pf_ack after exactly 4 denied cycles; counter returns to 0.
- Back-to-back pf reads of addrs 0..7 preloaded with values 0..7 -> pf_rvalid high 8 consecutive cycles, pf_rdata 0..7 in order.
- resetl pulsed low during an outstanding read -> all acks/rvalids 0 immediately, no rvalid after release; with GPU_RAM_ARB_STATS_EN, conflict_cnt=0.
